// File: rtl/huff_pair_decoder.sv
// huff_pair_decoder
//   MP3 big_values Huffman pair decoder for every table (0..31). Bits arrive
//   serially (MSB-first) on a valid/ready port, are accumulated into a code
//   register and matched by an external combinational ROM. After a match the
//   optional linbits extension and sign bits are read per value, and a signed
//   (x,y) pair is offered on a valid/ready output. A programmed number of pairs
//   is decoded per start, followed by a one-cycle done pulse.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start                    latch table_sel/linbits/pair_count (IDLE/ERR only)
//   table_sel[4:0]           Huffman table number
//   linbits[3:0]             linbits for the table (0..MAX_LIN)
//   pair_count[8:0]          pairs to decode
//   axiiv/axiid/axiir        input bit stream (valid, data, ready)
//   lu_table/lu_len/lu_code  lookup request to the ROM (right-aligned code)
//   lu_hit/lu_x/lu_y         ROM response, same cycle
//   axiov/axior              output pair handshake
//   x_val, y_val[15:0]       signed decoded values
//   done                     one-cycle pulse after last pair transferred
//   err                      sticky: no codeword within MAX_BITS bits
module huff_pair_decoder #(
  parameter int MAX_BITS = 19,
  parameter int MAX_LIN  = 13
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4:0]          table_sel,
  input  logic [3:0]          linbits,
  input  logic [8:0]          pair_count,
  input  logic                axiiv,
  input  logic                axiid,
  output logic                axiir,
  output logic [4:0]          lu_table,
  output logic [4:0]          lu_len,
  output logic [MAX_BITS-1:0] lu_code,
  input  logic                lu_hit,
  input  logic [3:0]          lu_x,
  input  logic [3:0]          lu_y,
  output logic                axiov,
  input  logic                axior,
  output logic [15:0]         x_val,
  output logic [15:0]         y_val,
  output logic                done,
  output logic                err
);

  typedef enum logic [3:0] {
    S_IDLE, S_CODE, S_LINX, S_SIGNX, S_LINY, S_SIGNY, S_OUT, S_DONE, S_ERR
  } state_t;

  localparam logic [4:0] LEN_MAX = 5'(MAX_BITS);

  state_t                state_q, state_d;
  logic [4:0]            tbl_q, tbl_d;
  logic [3:0]            lb_q, lb_d;
  logic [8:0]            rem_q, rem_d;
  logic [4:0]            len_q, len_d;
  logic [MAX_BITS-1:0]   code_q, code_d;
  logic [3:0]            xabs_q, xabs_d, yabs_q, yabs_d;
  logic [MAX_LIN-1:0]    lin_q, lin_d;
  logic [3:0]            lcnt_q, lcnt_d;
  logic [15:0]           xv_q, xv_d, yv_q, yv_d;
  logic                  err_q, err_d;
  logic                  ir;
  logic [MAX_LIN:0]      lin_ext;
  logic                  lin_last;

  // Next field after position 'from' (0=code,1=linx,2=signx,3=liny,4=signy).
  // Absent fields are skipped without spending a cycle.
  function automatic state_t field_next(input logic [2:0] from,
                                        input logic [3:0] xa, ya, lb);
    if (from < 3'd1 && xa == 4'd15 && lb != 4'd0) return S_LINX;
    if (from < 3'd2 && xa != 4'd0)                return S_SIGNX;
    if (from < 3'd3 && ya == 4'd15 && lb != 4'd0) return S_LINY;
    if (from < 3'd4 && ya != 4'd0)                return S_SIGNY;
    return S_OUT;
  endfunction

  assign lin_ext  = {lin_q, axiid};
  assign lin_last = (lcnt_q == lb_q - 4'd1);

  always_comb begin
    state_d = state_q;
    tbl_d   = tbl_q;
    lb_d    = lb_q;
    rem_d   = rem_q;
    len_d   = len_q;
    code_d  = code_q;
    xabs_d  = xabs_q;
    yabs_d  = yabs_q;
    lin_d   = lin_q;
    lcnt_d  = lcnt_q;
    xv_d    = xv_q;
    yv_d    = yv_q;
    err_d   = err_q;
    ir      = 1'b0;
    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          tbl_d   = table_sel;
          lb_d    = linbits;
          rem_d   = pair_count;
          err_d   = 1'b0;
          len_d   = '0;
          code_d  = '0;
          state_d = (pair_count == 9'd0) ? S_DONE : S_CODE;
        end
      end
      S_CODE: begin
        if (tbl_q == 5'd0) begin
          xv_d    = '0;
          yv_d    = '0;
          state_d = S_OUT;
        end else if (len_q != 5'd0 && lu_hit) begin
          // Match cycle consumes no bit: one bubble per codeword.
          xabs_d  = lu_x;
          yabs_d  = lu_y;
          xv_d    = 16'(lu_x);
          yv_d    = 16'(lu_y);
          len_d   = '0;
          code_d  = '0;
          lin_d   = '0;
          lcnt_d  = '0;
          state_d = field_next(3'd0, lu_x, lu_y, lb_q);
        end else if (len_q == LEN_MAX) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          ir = 1'b1;
          if (axiiv) begin
            code_d = {code_q[MAX_BITS-2:0], axiid};
            len_d  = len_q + 5'd1;
          end
        end
      end
      S_LINX, S_LINY: begin
        ir = 1'b1;
        if (axiiv) begin
          lin_d  = lin_ext[MAX_LIN-1:0];
          lcnt_d = lcnt_q + 4'd1;
          if (lin_last) begin
            lin_d  = '0;
            lcnt_d = '0;
            if (state_q == S_LINX) begin
              xv_d    = 16'(xabs_q) + 16'(lin_ext);
              state_d = field_next(3'd1, xabs_q, yabs_q, lb_q);
            end else begin
              yv_d    = 16'(yabs_q) + 16'(lin_ext);
              state_d = field_next(3'd3, xabs_q, yabs_q, lb_q);
            end
          end
        end
      end
      S_SIGNX: begin
        ir = 1'b1;
        if (axiiv) begin
          if (axiid) xv_d = -xv_q;
          state_d = field_next(3'd2, xabs_q, yabs_q, lb_q);
        end
      end
      S_SIGNY: begin
        ir = 1'b1;
        if (axiiv) begin
          if (axiid) yv_d = -yv_q;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (axior) begin
          rem_d   = rem_q - 9'd1;
          state_d = (rem_q == 9'd1) ? S_DONE : S_CODE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tbl_q   <= '0;
      lb_q    <= '0;
      rem_q   <= '0;
      len_q   <= '0;
      code_q  <= '0;
      xabs_q  <= '0;
      yabs_q  <= '0;
      lin_q   <= '0;
      lcnt_q  <= '0;
      xv_q    <= '0;
      yv_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tbl_q   <= tbl_d;
      lb_q    <= lb_d;
      rem_q   <= rem_d;
      len_q   <= len_d;
      code_q  <= code_d;
      xabs_q  <= xabs_d;
      yabs_q  <= yabs_d;
      lin_q   <= lin_d;
      lcnt_q  <= lcnt_d;
      xv_q    <= xv_d;
      yv_q    <= yv_d;
      err_q   <= err_d;
    end
  end

  assign axiir    = ir;
  assign lu_table = tbl_q;
  assign lu_len   = len_q;
  assign lu_code  = code_q;
  assign axiov    = (state_q == S_OUT);
  assign x_val    = xv_q;
  assign y_val    = yv_q;
  assign done     = (state_q == S_DONE);
  assign err      = err_q;

endmodule
